neat_mpe_pipe: RTL and testbench

//  Parametrised, pipelined NEAT crossover+mutation PE; one child gene per accepted parent pair.

---
 rtl/neat_pkg.sv | 15 +
 rtl/neat_attr_lane.sv | 24 ++
 rtl/neat_mpe_pipe.sv | 123 ++++++++++++
 tb/tb_neat_mpe_pipe.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neat_pkg.sv
// neat_pkg: shared constants for the NEAT crossover+mutation PE
package neat_pkg;
    localparam int ATTR_SZ_DEF = 8;
    localparam logic [4:0] CFG_FIT1 = 5'd0;
    localparam logic [4:0] CFG_FIT2 = 5'd1;
    localparam logic [4:0] CFG_GID  = 5'd2;
    localparam logic [4:0] CFG_NODE = 5'd8;
    localparam logic [4:0] CFG_CONN = 5'd16;
    localparam int HDR_TYPE_FROM_TOP = 2;
    localparam int CONN_FLIP_LANE = 1;
    typedef enum logic {GT_NODE = 1'b0, GT_CONN = 1'b1} gene_type_e;
    function automatic logic cfg_mapped(input logic [4:0] a, input int n);
        return a <= CFG_GID || ((a[4:3] == 2'b01 || a[4:3] == 2'b10) && int'(a[2:0]) < n);
    endfunction
endpackage

// File: rtl/neat_attr_lane.sv
// neat_attr_lane: crossover select (stage 1) and mutate decision/value (stage 2) for one lane
module neat_attr_lane #(
    parameter int ATTR_SZ = 8,
    parameter int XO_BIAS = 2,
    parameter bit FLIP    = 1'b0
) (
    input  logic [ATTR_SZ-1:0] a_fit,
    input  logic [ATTR_SZ-1:0] a_oth,
    input  logic [ATTR_SZ-1:0] sel,
    input  logic [ATTR_SZ-1:0] x_in,
    input  logic [ATTR_SZ-1:0] rnd_mut,
    input  logic [ATTR_SZ-1:0] rnd_val,
    input  logic [ATTR_SZ-1:0] prob,
    input  logic               is_conn,
    output logic [ATTR_SZ-1:0] xo,
    output logic [ATTR_SZ-1:0] val,
    output logic               mut
);
    always_comb begin
        xo  = (sel[ATTR_SZ-1 -: XO_BIAS] == '0) ? a_oth : a_fit;
        mut = rnd_mut < prob;
        val = !mut ? x_in : (FLIP && is_conn) ? (x_in ^ ATTR_SZ'(1)) : rnd_val;
    end
endmodule

// File: rtl/neat_mpe_pipe.sv
// neat_mpe_pipe: 2-stage NEAT crossover+mutation PE with config regs and valid/ready flow
module neat_mpe_pipe
    import neat_pkg::*;
#(
    parameter int ATTR_SZ = ATTR_SZ_DEF,
    parameter int N_ATTR  = 4,
    parameter int N_HDR   = 4,
    parameter int XO_BIAS = 2,
    localparam int AW      = N_ATTR * ATTR_SZ,
    localparam int HW      = N_HDR * ATTR_SZ,
    localparam int GENE_SZ = AW + HW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [4:0]         cfg_addr,
    input  logic [ATTR_SZ-1:0] cfg_data,
    output logic               cfg_err,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [GENE_SZ-1:0] gene1,
    input  logic [GENE_SZ-1:0] gene2,
    input  logic [AW-1:0]      rnd_sel,
    input  logic [AW-1:0]      rnd_mut,
    input  logic [AW-1:0]      rnd_val,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [GENE_SZ-1:0] child_gene,
    output logic [N_ATTR-1:0]  child_mut_mask,
    output logic [15:0]        child_cnt
);
    logic [ATTR_SZ-1:0] fit1, fit2, genome_id;
    logic [ATTR_SZ-1:0] node_prob [N_ATTR];
    logic [ATTR_SZ-1:0] conn_prob [N_ATTR];
    logic               s1_valid;
    logic [AW-1:0]      s1_xo, s1_mut, s1_val;
    logic [HW-1:0]      s1_hdr;
    logic [GENE_SZ-1:0] fitter, other;
    logic [AW-1:0]      xo, mval;
    logic [N_ATTR-1:0]  mut;
    logic               s2_adv, accept, cfg_ok, is_conn;

    always_comb begin
        fitter   = (fit2 > fit1) ? gene2 : gene1;
        other    = (fit2 > fit1) ? gene1 : gene2;
        s2_adv   = !out_valid || out_ready;
        in_ready = !s1_valid || s2_adv;
        accept   = in_valid && in_ready;
        is_conn  = gene_type_e'(s1_hdr[HW-(HDR_TYPE_FROM_TOP-1)*ATTR_SZ-1]) == GT_CONN;
        cfg_ok   = cfg_mapped(cfg_addr, N_ATTR) && !s1_valid && !out_valid && !accept;
    end

    for (genvar i = 0; i < N_ATTR; i++) begin : g_lane
        neat_attr_lane #(
            .ATTR_SZ(ATTR_SZ),
            .XO_BIAS(XO_BIAS),
            .FLIP(i == CONN_FLIP_LANE)
        ) u_lane (
            .a_fit  (fitter[i*ATTR_SZ +: ATTR_SZ]),
            .a_oth  (other[i*ATTR_SZ +: ATTR_SZ]),
            .sel    (rnd_sel[i*ATTR_SZ +: ATTR_SZ]),
            .x_in   (s1_xo[i*ATTR_SZ +: ATTR_SZ]),
            .rnd_mut(s1_mut[i*ATTR_SZ +: ATTR_SZ]),
            .rnd_val(s1_val[i*ATTR_SZ +: ATTR_SZ]),
            .prob   (is_conn ? conn_prob[i] : node_prob[i]),
            .is_conn(is_conn),
            .xo     (xo[i*ATTR_SZ +: ATTR_SZ]),
            .val    (mval[i*ATTR_SZ +: ATTR_SZ]),
            .mut    (mut[i])
        );
    end

    // Writes are only honoured with the pipe empty, so stage 2 may read config live
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            fit1      <= '0;
            fit2      <= '0;
            genome_id <= '0;
            cfg_err   <= 1'b0;
            for (int j = 0; j < N_ATTR; j++) begin
                node_prob[j] <= '0;
                conn_prob[j] <= '0;
            end
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_we && cfg_ok) begin
                if (cfg_addr == CFG_FIT1) fit1 <= cfg_data;
                if (cfg_addr == CFG_FIT2) fit2 <= cfg_data;
                if (cfg_addr == CFG_GID) genome_id <= cfg_data;
                for (int j = 0; j < N_ATTR; j++) begin
                    if (cfg_addr == CFG_NODE + 5'(j)) node_prob[j] <= cfg_data;
                    if (cfg_addr == CFG_CONN + 5'(j)) conn_prob[j] <= cfg_data;
                end
            end
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1_valid       <= 1'b0;
            s1_xo          <= '0;
            s1_mut         <= '0;
            s1_val         <= '0;
            s1_hdr         <= '0;
            out_valid      <= 1'b0;
            child_gene     <= '0;
            child_mut_mask <= '0;
            child_cnt      <= '0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (accept) begin
                s1_xo  <= xo;
                s1_mut <= rnd_mut;
                s1_val <= rnd_val;
                s1_hdr <= fitter[GENE_SZ-1:AW];
            end
            if (s2_adv) out_valid <= s1_valid;
            if (s2_adv && s1_valid) begin
                child_gene     <= {genome_id, s1_hdr[HW-ATTR_SZ-1:0], mval};
                child_mut_mask <= mut;
            end
            if (out_valid && out_ready) child_cnt <= child_cnt + 16'd1;
        end
endmodule

// File: tb/tb_neat_mpe_pipe.sv
// tb_neat_mpe_pipe: scoreboard bench for the NEAT crossover+mutation PE
module tb_neat_mpe_pipe;
    logic        clk = 1'b0, rst = 1'b1, cfg_we = 1'b0;
    logic [4:0]  cfg_addr = '0;
    logic [7:0]  cfg_data = '0;
    logic        cfg_err, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [63:0] gene1 = '0, gene2 = '0, child_gene;
    logic [31:0] rnd_sel = '0, rnd_mut = '0, rnd_val = '0;
    logic [3:0]  child_mut_mask;
    logic [15:0] child_cnt;
    int          checks = 0, errors = 0;
    logic [67:0] sb [$];
    logic [7:0]  m_fit1, m_fit2, m_gid;
    logic [7:0]  m_node [4];
    logic [7:0]  m_conn [4];

    neat_mpe_pipe dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready), .gene1(gene1),
        .gene2(gene2), .rnd_sel(rnd_sel), .rnd_mut(rnd_mut), .rnd_val(rnd_val),
        .out_valid(out_valid), .out_ready(out_ready), .child_gene(child_gene),
        .child_mut_mask(child_mut_mask), .child_cnt(child_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [67:0] model(input logic [63:0] g1, g2, input logic [31:0] s, mu, v);
        logic [63:0] f, o, c;
        logic [3:0]  mk;
        logic [7:0]  x, p;
        logic        t;
        f = (m_fit2 > m_fit1) ? g2 : g1;
        o = (m_fit2 > m_fit1) ? g1 : g2;
        t = f[55];
        c = f;
        mk = '0;
        for (int i = 0; i < 4; i++) begin
            x = (s[i*8+6 +: 2] == 2'b00) ? o[i*8 +: 8] : f[i*8 +: 8];
            p = t ? m_conn[i] : m_node[i];
            if (mu[i*8 +: 8] < p) begin
                mk[i] = 1'b1;
                c[i*8 +: 8] = (t && i == 1) ? {x[7:1], ~x[0]} : v[i*8 +: 8];
            end else
                c[i*8 +: 8] = x;
        end
        c[63:56] = m_gid;
        return {mk, c};
    endfunction

    always @(negedge clk) begin : mon
        logic [67:0] e;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_child got %h", child_gene);
            end else begin
                e = sb.pop_front();
                if ({child_mut_mask, child_gene} !== e) begin
                    errors++;
                    $display("FAIL child got mask %b gene %h want mask %b gene %h",
                             child_mut_mask, child_gene, e[67:64], e[63:0]);
                end
            end
        end
    end

    task automatic zero_model;
        m_fit1 = '0; m_fit2 = '0; m_gid = '0;
        for (int i = 0; i < 4; i++) begin
            m_node[i] = '0;
            m_conn[i] = '0;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
        sb.delete();
        zero_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [4:0] a, input logic [7:0] d, input logic err);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        checks++;
        if (cfg_err !== err) begin
            errors++;
            $display("FAIL cfg_err addr %0d got %b want %b", a, cfg_err, err);
        end
        if (!err) begin
            if (a == 0) m_fit1 = d;
            else if (a == 1) m_fit2 = d;
            else if (a == 2) m_gid = d;
            else if (a >= 8 && a < 12) m_node[a-8] = d;
            else if (a >= 16 && a < 20) m_conn[a-16] = d;
        end
    endtask

    task automatic send(input logic [63:0] g1, g2, input logic [31:0] s, mu, v);
        int k = 0;
        gene1 = g1; gene2 = g2; rnd_sel = s; rnd_mut = mu; rnd_val = v; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL in_ready_timeout got %b want 1", in_ready);
        end else
            sb.push_back(model(g1, g2, s, mu, v));
        @(posedge clk); #1;
    endtask

    task automatic drain;
        int k = 0;
        in_valid = 1'b0;
        while ((sb.size() != 0 || out_valid) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (sb.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL drain_timeout pending %0d want 0", sb.size());
        end
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({out_valid, in_ready, cfg_err, child_mut_mask, child_cnt, child_gene} !== {3'b010, 4'h0, 16'h0, 64'h0}) begin
            errors++;
            $display("FAIL reset_state got ov=%b ir=%b err=%b mask=%b cnt=%h gene=%h want 0 1 0 0 0 0",
                     out_valid, in_ready, cfg_err, child_mut_mask, child_cnt, child_gene);
        end
    endtask

    task automatic test_fitter;
        logic [63:0] g1, g2;
        do_reset();
        cfg_write(5'd0, 8'd10, 1'b0);
        cfg_write(5'd1, 8'd20, 1'b0);
        cfg_write(5'd2, 8'hA5, 1'b0);
        g1 = {$urandom, $urandom};
        g2 = {$urandom, $urandom} & ~(64'h1 << 55);
        send(g1, g2, 32'hFFFF_FFFF, $urandom, $urandom);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early out_valid got %b want 0", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || child_gene !== {8'hA5, g2[55:0]} || child_mut_mask !== 4'b0) begin
            errors++;
            $display("FAIL fitter_child got ov=%b %h mask %b want 1 %h 0000",
                     out_valid, child_gene, child_mut_mask, {8'hA5, g2[55:0]});
        end
        drain();
    endtask

    task automatic test_tie;
        logic [63:0] g1;
        do_reset();
        cfg_write(5'd0, 8'd7, 1'b0);
        cfg_write(5'd1, 8'd7, 1'b0);
        g1 = {$urandom, $urandom} & ~(64'h1 << 55);
        send(g1, {$urandom, $urandom}, 32'hFFFF_FF00, $urandom, $urandom);
        for (int i = 0; i < 4; i++)
            send({$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom, $urandom);
        drain();
    endtask

    task automatic test_mutation;
        do_reset();
        cfg_write(5'd17, 8'hFF, 1'b0);
        cfg_write(5'd10, 8'h80, 1'b0);
        cfg_write(5'd11, 8'hFF, 1'b0);
        send(64'hEE80_1234_4433_0111, {$urandom, $urandom}, 32'hFFFF_FFFF, 32'h0000_1000, $urandom);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (child_gene !== 64'h0080_1234_4433_0011 || child_mut_mask !== 4'b0010) begin
            errors++;
            $display("FAIL conn_flip got %h %b want 0080123444330011 0010", child_gene, child_mut_mask);
        end
        drain();
        send(64'h0000_5678_4433_2211, {$urandom, $urandom}, 32'hFFFF_FFFF, 32'hFF7F_0000, 32'hABCD_EF01);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (child_gene !== 64'h0000_5678_44CD_2211 || child_mut_mask !== 4'b0100) begin
            errors++;
            $display("FAIL node_mut got %h %b want 0000567844CD2211 0100", child_gene, child_mut_mask);
        end
        drain();
        send(64'h0080_0000_0000_0000 | {32'h0, $urandom}, {$urandom, $urandom}, $urandom, 32'h0000_FF00, $urandom);
        drain();
    endtask

    task automatic test_back_to_back;
        logic [63:0] snap;
        logic [3:0]  snapm;
        do_reset();
        cfg_write(5'd2, 8'($urandom), 1'b0);
        cfg_write(5'd0, 8'($urandom), 1'b0);
        cfg_write(5'd1, 8'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) begin
            cfg_write(5'(8 + i), 8'($urandom), 1'b0);
            cfg_write(5'(16 + i), 8'($urandom), 1'b0);
        end
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send({$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom, $urandom);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                snap = child_gene;
                snapm = child_mut_mask;
                repeat (3) begin
                    @(posedge clk); #1;
                    checks++;
                    if (out_valid !== 1'b1 || child_gene !== snap || child_mut_mask !== snapm) begin
                        errors++;
                        $display("FAIL stall_hold got ov=%b %h %b want 1 %h %b",
                                 out_valid, child_gene, child_mut_mask, snap, snapm);
                    end
                end
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready got %b want 0", in_ready);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (child_cnt !== 16'd8) begin
            errors++;
            $display("FAIL stream_cnt got %0d want 8", child_cnt);
        end
    endtask

    task automatic test_cfg_err;
        logic [63:0] g1, g2;
        logic [31:0] s, mu, v;
        do_reset();
        cfg_write(5'd2, 8'h3C, 1'b0);
        cfg_write(5'd31, 8'h11, 1'b1);
        cfg_write(5'd3, 8'h11, 1'b1);
        cfg_write(5'd12, 8'h11, 1'b1);
        cfg_write(5'd20, 8'h11, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_pulse got %b want 0", cfg_err);
        end
        out_ready = 1'b0;
        send({$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom, $urandom);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL busy_setup out_valid got %b want 1", out_valid);
        end
        cfg_write(5'd2, 8'hC3, 1'b1);
        out_ready = 1'b1;
        drain();
        send({$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom, $urandom);
        drain();
        g1 = {$urandom, $urandom}; g2 = {$urandom, $urandom};
        s = $urandom; mu = $urandom; v = $urandom;
        gene1 = g1; gene2 = g2; rnd_sel = s; rnd_mut = mu; rnd_val = v; in_valid = 1'b1;
        sb.push_back(model(g1, g2, s, mu, v));
        cfg_write(5'd2, 8'h99, 1'b1);
        drain();
        send({$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom, $urandom);
        drain();
    endtask

    task automatic test_reset_mid;
        logic [63:0] g1;
        do_reset();
        cfg_write(5'd2, 8'h77, 1'b0);
        cfg_write(5'd0, 8'd1, 1'b0);
        cfg_write(5'd1, 8'd9, 1'b0);
        cfg_write(5'd8, 8'hFF, 1'b0);
        send({$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom, $urandom);
        drain();
        out_ready = 1'b0;
        send({$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom, $urandom);
        send({$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom, $urandom);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || child_cnt !== 16'd1) begin
            errors++;
            $display("FAIL full_setup got ov=%b ir=%b cnt=%0d want 1 0 1", out_valid, in_ready, child_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || child_cnt !== 16'd0 || child_gene !== 64'h0) begin
            errors++;
            $display("FAIL async_reset got ov=%b ir=%b cnt=%0d gene=%h want 0 1 0 0",
                     out_valid, in_ready, child_cnt, child_gene);
        end
        sb.delete();
        zero_model();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        g1 = {$urandom, $urandom};
        send(g1, {$urandom, $urandom}, 32'hFFFF_FFFF, 32'h0, $urandom);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (child_gene !== {8'h00, g1[55:0]} || child_mut_mask !== 4'b0) begin
            errors++;
            $display("FAIL post_reset_cfg got %h %b want %h 0000", child_gene, child_mut_mask, {8'h00, g1[55:0]});
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_fitter();
        test_tie();
        test_mutation();
        test_back_to_back();
        test_cfg_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
